// File: rtl/bp_be_dual_issue_arbiter.sv
// Dual-issue arbiter: buffers an in-order FE pair and decides
// whether the oldest two issue together or split.
module bp_be_dual_issue_arbiter #(
  parameter int pkt_width_p = 128,
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   dual_en_i,
  input  logic                   flush_i,
  input  logic                   fe_v1_i,
  input  logic [pkt_width_p-1:0] fe_pkt1_i,
  input  logic [18:0]            fe_info1_i,
  input  logic                   fe_v2_i,
  input  logic [pkt_width_p-1:0] fe_pkt2_i,
  input  logic [18:0]            fe_info2_i,
  output logic                   fe_ready_o,
  output logic                   iss_v0_o,
  output logic [pkt_width_p-1:0] iss_pkt0_o,
  output logic                   iss_v1_o,
  output logic [pkt_width_p-1:0] iss_pkt1_o,
  input  logic                   iss_ready_i,
  output logic [cnt_width_p-1:0] dual_cnt_o
);

  typedef struct packed {
    logic       serial;
    logic       lng;
    logic       mem;
    logic       rd_w_v;
    logic [4:0] rd;
    logic [4:0] rs2;
    logic [4:0] rs1;
  } info_t;

  localparam logic [cnt_width_p-1:0] CntOne = 1;
  localparam logic [cnt_width_p-1:0] CntMax = '1;

  logic [pkt_width_p-1:0] e0_pkt_q, e0_pkt_d;
  logic [pkt_width_p-1:0] e1_pkt_q, e1_pkt_d;
  info_t                  e0_info_q, e0_info_d;
  info_t                  e1_info_q, e1_info_d;
  logic [1:0]             count_q, count_d;
  logic [cnt_width_p-1:0] dual_cnt_q, dual_cnt_d;

  logic pair_ok;
  logic raw_hz;
  logic waw_hz;
  logic consume;
  logic drain_all;
  logic accept;
  logic unused_rs;

  // e0 source operands never gate pairing
  assign unused_rs = ^{e0_info_q.rs2, e0_info_q.rs1};

  // Pairing rules on the two buffered entries
  always_comb begin
    raw_hz = e0_info_q.rd_w_v & (e0_info_q.rd != 5'd0)
           & ((e0_info_q.rd == e1_info_q.rs1)
           |  (e0_info_q.rd == e1_info_q.rs2));
    waw_hz = e0_info_q.rd_w_v & e1_info_q.rd_w_v
           & (e0_info_q.rd != 5'd0)
           & (e0_info_q.rd == e1_info_q.rd);
    pair_ok = dual_en_i
            & ~e0_info_q.serial & ~e1_info_q.serial
            & ~(e0_info_q.mem & e1_info_q.mem)
            & ~(e0_info_q.lng & e1_info_q.lng)
            & ~raw_hz & ~waw_hz;
  end

  assign iss_v0_o   = (count_q != 2'd0) & ~flush_i;
  assign iss_v1_o   = (count_q == 2'd2) & pair_ok & ~flush_i;
  assign iss_pkt0_o = e0_pkt_q;
  assign iss_pkt1_o = e1_pkt_q;
  assign dual_cnt_o = dual_cnt_q;

  assign consume   = iss_ready_i & iss_v0_o;
  assign drain_all = (count_q == 2'd0)
                   | (iss_ready_i
                   & ((count_q == 2'd1) | iss_v1_o));
  assign fe_ready_o = drain_all & ~flush_i;
  assign accept     = fe_ready_o & fe_v1_i;

  // Buffer next state: flush, then accept, then consume
  always_comb begin
    e0_pkt_d  = e0_pkt_q;
    e1_pkt_d  = e1_pkt_q;
    e0_info_d = e0_info_q;
    e1_info_d = e1_info_q;
    count_d   = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (accept) begin
      e0_pkt_d  = fe_pkt1_i;
      e0_info_d = info_t'(fe_info1_i);
      if (fe_v2_i) begin
        e1_pkt_d  = fe_pkt2_i;
        e1_info_d = info_t'(fe_info2_i);
      end
      count_d = fe_v2_i ? 2'd2 : 2'd1;
    end else if (consume) begin
      if (iss_v1_o) begin
        count_d = 2'd0;
      end else begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          e0_pkt_d  = e1_pkt_q;
          e0_info_d = e1_info_q;
        end
      end
    end
  end

  // Saturating count of consumed dual issues
  always_comb begin
    dual_cnt_d = dual_cnt_q;
    if (iss_ready_i & iss_v1_o & (dual_cnt_q != CntMax)) begin
      dual_cnt_d = dual_cnt_q + CntOne;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      e0_pkt_q   <= '0;
      e1_pkt_q   <= '0;
      e0_info_q  <= '0;
      e1_info_q  <= '0;
      count_q    <= 2'd0;
      dual_cnt_q <= '0;
    end else begin
      e0_pkt_q   <= e0_pkt_d;
      e1_pkt_q   <= e1_pkt_d;
      e0_info_q  <= e0_info_d;
      e1_info_q  <= e1_info_d;
      count_q    <= count_d;
      dual_cnt_q <= dual_cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_be_dual_issue_arbiter.sv
// Directed bench for the dual-issue arbiter: pairing-rule
// table plus backpressure, flush, streaming, saturation, reset.
module tb_bp_be_dual_issue_arbiter;

  localparam int PW = 128;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          dual_en;
  logic          flush;
  logic          fe_v1;
  logic [PW-1:0] fe_pkt1;
  logic [18:0]   fe_info1;
  logic          fe_v2;
  logic [PW-1:0] fe_pkt2;
  logic [18:0]   fe_info2;
  logic          fe_ready;
  logic          iss_v0;
  logic [PW-1:0] iss_pkt0;
  logic          iss_v1;
  logic [PW-1:0] iss_pkt1;
  logic          iss_ready;
  logic [CW-1:0] dual_cnt;

  int checks;
  int errors;
  int exp_cnt;

  bp_be_dual_issue_arbiter #(
    .pkt_width_p(PW),
    .cnt_width_p(CW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .dual_en_i  (dual_en),
    .flush_i    (flush),
    .fe_v1_i    (fe_v1),
    .fe_pkt1_i  (fe_pkt1),
    .fe_info1_i (fe_info1),
    .fe_v2_i    (fe_v2),
    .fe_pkt2_i  (fe_pkt2),
    .fe_info2_i (fe_info2),
    .fe_ready_o (fe_ready),
    .iss_v0_o   (iss_v0),
    .iss_pkt0_o (iss_pkt0),
    .iss_v1_o   (iss_v1),
    .iss_pkt1_o (iss_pkt1),
    .iss_ready_i(iss_ready),
    .dual_cnt_o (dual_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [18:0] i1;
    logic [18:0] i2;
    logic        den;
    logic        pair;
  } vec_t;

  vec_t vt[14];

  function automatic logic [18:0] mk(
    input logic s, input logic l, input logic m,
    input logic w, input logic [4:0] rd,
    input logic [4:0] rs2, input logic [4:0] rs1);
    return {s, l, m, w, rd, rs2, rs1};
  endfunction

  task automatic chk(input string nm,
                     input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic idle_in();
    fe_v1 = 1'b0;
    fe_v2 = 1'b0;
    flush = 1'b0;
    iss_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    pa = {4{32'hAAAA0000 | 32'(i)}};
    pb = {4{32'hBBBB0000 | 32'(i)}};
    fe_v1 = 1'b1;
    fe_v2 = 1'b1;
    fe_info1 = vt[i].i1;
    fe_info2 = vt[i].i2;
    fe_pkt1 = pa;
    fe_pkt2 = pb;
    dual_en = vt[i].den;
    iss_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_rdy_empty", i), PW'(fe_ready), PW'(1));
    cyc();
    fe_v1 = 1'b0;
    fe_v2 = 1'b0;
    #1;
    chk($sformatf("v%0d_v0", i), PW'(iss_v0), PW'(1));
    chk($sformatf("v%0d_v1", i), PW'(iss_v1), PW'(vt[i].pair));
    chk($sformatf("v%0d_pkt0", i), iss_pkt0, pa);
    chk($sformatf("v%0d_rdy_full", i), PW'(fe_ready), PW'(0));
    if (vt[i].pair) chk($sformatf("v%0d_pkt1", i), iss_pkt1, pb);
    iss_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_rdy_drain", i), PW'(fe_ready),
        PW'(vt[i].pair));
    cyc();
    if (vt[i].pair) begin
      bump();
    end else begin
      chk($sformatf("v%0d_split_v0", i), PW'(iss_v0), PW'(1));
      chk($sformatf("v%0d_split_v1", i), PW'(iss_v1), PW'(0));
      chk($sformatf("v%0d_split_pkt", i), iss_pkt0, pb);
      chk($sformatf("v%0d_split_rdy", i), PW'(fe_ready), PW'(1));
      cyc();
    end
    chk($sformatf("v%0d_empty", i), PW'(iss_v0), PW'(0));
    chk($sformatf("v%0d_cnt", i), PW'(dual_cnt), PW'(exp_cnt));
    iss_ready = 1'b0;
    dual_en = 1'b1;
  endtask

  logic [18:0] ind1;
  logic [18:0] ind2;

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    dual_en = 1'b1;
    fe_pkt1 = '0;
    fe_pkt2 = '0;
    fe_info1 = '0;
    fe_info2 = '0;
    idle_in();

    ind1 = mk(0, 0, 0, 1, 5'd5, 5'd2, 5'd1);
    ind2 = mk(0, 0, 0, 1, 5'd6, 5'd4, 5'd3);
    vt[0]  = '{ind1, ind2, 1'b1, 1'b1};
    vt[1]  = '{ind1, mk(0,0,0,1,5'd6,5'd4,5'd5), 1'b1, 1'b0};
    vt[2]  = '{ind1, mk(0,0,0,1,5'd6,5'd5,5'd3), 1'b1, 1'b0};
    vt[3]  = '{ind1, mk(0,0,0,1,5'd5,5'd4,5'd3), 1'b1, 1'b0};
    vt[4]  = '{mk(0,0,0,0,5'd5,5'd2,5'd1),
               mk(0,0,0,1,5'd5,5'd5,5'd5), 1'b1, 1'b1};
    vt[5]  = '{mk(0,0,1,1,5'd5,5'd2,5'd1),
               mk(0,0,1,1,5'd6,5'd4,5'd3), 1'b1, 1'b0};
    vt[6]  = '{mk(0,0,1,1,5'd5,5'd2,5'd1), ind2, 1'b1, 1'b1};
    vt[7]  = '{mk(0,1,0,1,5'd5,5'd2,5'd1),
               mk(0,1,0,1,5'd6,5'd4,5'd3), 1'b1, 1'b0};
    vt[8]  = '{mk(0,1,0,1,5'd5,5'd2,5'd1),
               mk(0,0,1,1,5'd6,5'd4,5'd3), 1'b1, 1'b1};
    vt[9]  = '{mk(1,0,0,1,5'd5,5'd2,5'd1), ind2, 1'b1, 1'b0};
    vt[10] = '{ind1, mk(1,0,0,1,5'd6,5'd4,5'd3), 1'b1, 1'b0};
    vt[11] = '{ind1, ind2, 1'b0, 1'b0};
    vt[12] = '{mk(0,0,0,1,5'd0,5'd2,5'd1),
               mk(0,0,0,1,5'd0,5'd4,5'd0), 1'b1, 1'b1};
    vt[13] = '{ind1, mk(0,0,0,1,5'd1,5'd4,5'd3), 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_v0", PW'(iss_v0), PW'(0));
    chk("rst_v1", PW'(iss_v1), PW'(0));
    chk("rst_rdy", PW'(fe_ready), PW'(1));
    chk("rst_cnt", PW'(dual_cnt), PW'(0));
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 14; i++) run_vec(i);

    // fe_v2 alone is ignored
    fe_v2 = 1'b1;
    fe_info2 = ind2;
    cyc();
    fe_v2 = 1'b0;
    #1;
    chk("v2only_v0", PW'(iss_v0), PW'(0));

    // single accept, then dual_en takes effect same cycle
    fe_v1 = 1'b1;
    fe_info1 = ind1;
    fe_pkt1 = {4{32'h11112222}};
    cyc();
    fe_v1 = 1'b0;
    #1;
    chk("single_v0", PW'(iss_v0), PW'(1));
    chk("single_v1", PW'(iss_v1), PW'(0));
    chk("single_pkt", iss_pkt0, {4{32'h11112222}});
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    fe_v1 = 1'b1;
    fe_v2 = 1'b1;
    fe_info1 = ind1;
    fe_info2 = ind2;
    dual_en = 1'b0;
    cyc();
    idle_in();
    #1;
    chk("den0_v1", PW'(iss_v1), PW'(0));
    dual_en = 1'b1;
    #1;
    chk("den1_v1", PW'(iss_v1), PW'(1));

    // backpressure then flush
    fe_pkt1 = {4{32'hC0DE0001}};
    fe_pkt2 = {4{32'hC0DE0002}};
    fe_v1 = 1'b1;
    fe_v2 = 1'b1;
    iss_ready = 1'b1;
    #1;
    cyc();
    bump();
    fe_v1 = 1'b0;
    fe_v2 = 1'b0;
    iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_v0", k), PW'(iss_v0), PW'(1));
      chk($sformatf("bp%0d_v1", k), PW'(iss_v1), PW'(1));
      chk($sformatf("bp%0d_pkt0", k), iss_pkt0, {4{32'hC0DE0001}});
      chk($sformatf("bp%0d_pkt1", k), iss_pkt1, {4{32'hC0DE0002}});
      chk($sformatf("bp%0d_rdy", k), PW'(fe_ready), PW'(0));
      cyc();
    end
    flush = 1'b1;
    fe_v1 = 1'b1;
    fe_v2 = 1'b1;
    iss_ready = 1'b1;
    #1;
    chk("fl_v0", PW'(iss_v0), PW'(0));
    chk("fl_v1", PW'(iss_v1), PW'(0));
    chk("fl_rdy", PW'(fe_ready), PW'(0));
    cyc();
    idle_in();
    #1;
    chk("fl_after_v0", PW'(iss_v0), PW'(0));
    chk("fl_after_rdy", PW'(fe_ready), PW'(1));
    chk("fl_after_cnt", PW'(dual_cnt), PW'(exp_cnt));

    // streaming dual issue up to saturation
    fe_info1 = ind1;
    fe_info2 = ind2;
    iss_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fe_v1 = 1'b1;
      fe_v2 = 1'b1;
      fe_pkt1 = {4{32'h50000000 | 32'(2*i)}};
      fe_pkt2 = {4{32'h50000000 | 32'(2*i+1)}};
      #1;
      if (i > 0) begin
        chk($sformatf("st%0d_v1", i), PW'(iss_v1), PW'(1));
        chk($sformatf("st%0d_rdy", i), PW'(fe_ready), PW'(1));
        chk($sformatf("st%0d_pkt0", i), iss_pkt0,
            {4{32'h50000000 | 32'(2*i-2)}});
      end
      cyc();
      if (i > 0) bump();
      chk($sformatf("st%0d_cnt", i), PW'(dual_cnt), PW'(exp_cnt));
    end
    fe_v1 = 1'b0;
    fe_v2 = 1'b0;
    cyc();
    bump();
    chk("sat_cnt", PW'(dual_cnt), PW'(15));

    // async reset mid-stream
    iss_ready = 1'b0;
    fe_v1 = 1'b1;
    fe_v2 = 1'b1;
    cyc();
    fe_v1 = 1'b0;
    fe_v2 = 1'b0;
    #1;
    chk("pre_rst_v0", PW'(iss_v0), PW'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_v0", PW'(iss_v0), PW'(0));
    chk("arst_cnt", PW'(dual_cnt), PW'(0));
    chk("arst_rdy", PW'(fe_ready), PW'(1));
    cyc();
    rst_n = 1'b1;
    exp_cnt = 0;
    cyc();
    chk("post_rst_v0", PW'(iss_v0), PW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
